// File: rtl/vec_accum.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vec_accum                                                     |
// | Purpose  : Streaming dot-product reduction. Each accepted beat carries   |
// |            LANES signed products. They are summed and then accumulated   |
// |            across a vector that ends with in_last. One ACC_W-bit result  |
// |            per vector is presented through a one-deep valid/ready        |
// |            output register.                                              |
// | Ports    : clk, rst (async, active-high)                                 |
// |            in_valid/in_ready/in_data/in_last   - beat input              |
// |            out_valid/out_ready                 - result handshake        |
// |            out_data  - signed vector sum                                 |
// |            out_beats - beat count of the reported vector                 |
// |            out_ovf   - saturation occurred in that vector                |
// | Options  : ACC_SAT_EN - saturating accumulation with a sticky overflow   |
// |            flag; when undefined, adds wrap and out_ovf is tied to 0.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module vec_accum #(
  parameter int LANES = 4,
  parameter int IN_W  = 16,
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*IN_W-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      out_data,
  output logic [CNT_W-1:0]      out_beats,
  output logic                  out_ovf
);

  localparam int SUM_W = IN_W + $clog2(LANES);

  logic                    acc_first_q, acc_first_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic [ACC_W-1:0]        out_data_q, out_data_d;
  logic [CNT_W-1:0]        out_beats_q, out_beats_d;

  logic                    w_beat;
  logic signed [SUM_W-1:0] w_lane_sum;
  logic signed [ACC_W-1:0] w_sum_ext;
  logic signed [ACC_W-1:0] w_base;
  logic signed [ACC_W-1:0] w_next;

  // A pending result never blocks a beat when it is consumed on the same edge.
  assign in_ready = !out_valid_q || out_ready;
  assign w_beat   = in_valid && in_ready;

  // Lane reduction: SUM_W bits cannot overflow for LANES products of IN_W bits.
  always_comb begin
    w_lane_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      w_lane_sum = w_lane_sum + SUM_W'($signed(in_data[k*IN_W +: IN_W]));
    end
  end

  assign w_sum_ext = ACC_W'(w_lane_sum);
  // The first beat of a vector starts from zero instead of the stale acc.
  assign w_base    = acc_first_q ? '0 : acc_q;

`ifdef ACC_SAT_EN
  logic                  ovf_q, ovf_d;
  logic                  out_ovf_q, out_ovf_d;
  logic signed [ACC_W:0] w_wide;
  logic                  w_sat_hit;
  logic                  w_ovf_next;

  // One guard bit: overflow iff the two top bits of the wide sum disagree.
  assign w_wide     = {w_base[ACC_W-1], w_base} + {w_sum_ext[ACC_W-1], w_sum_ext};
  assign w_sat_hit  = w_wide[ACC_W] != w_wide[ACC_W-1];
  assign w_next     = !w_sat_hit      ? w_wide[ACC_W-1:0] :
                      w_wide[ACC_W]   ? {1'b1, {(ACC_W-1){1'b0}}} :
                                        {1'b0, {(ACC_W-1){1'b1}}};
  assign w_ovf_next = (acc_first_q ? 1'b0 : ovf_q) | w_sat_hit;
  assign out_ovf    = out_ovf_q;
`else
  assign w_next     = w_base + w_sum_ext;
  assign out_ovf    = 1'b0;
`endif

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    acc_first_d = acc_first_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_beats_d = out_beats_q;
`ifdef ACC_SAT_EN
    ovf_d       = ovf_q;
    out_ovf_d   = out_ovf_q;
`endif
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (w_beat) begin
      if (in_last) begin
        out_valid_d = 1'b1;
        out_data_d  = w_next;
        out_beats_d = cnt_q + 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
        acc_first_d = 1'b1;
`ifdef ACC_SAT_EN
        out_ovf_d   = w_ovf_next;
        ovf_d       = 1'b0;
`endif
      end else begin
        acc_d       = w_next;
        cnt_d       = cnt_q + 1'b1;
        acc_first_d = 1'b0;
`ifdef ACC_SAT_EN
        ovf_d       = w_ovf_next;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      acc_first_q <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_beats_q <= '0;
`ifdef ACC_SAT_EN
      ovf_q       <= 1'b0;
      out_ovf_q   <= 1'b0;
`endif
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      acc_first_q <= acc_first_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_beats_q <= out_beats_d;
`ifdef ACC_SAT_EN
      ovf_q       <= ovf_d;
      out_ovf_q   <= out_ovf_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_beats = out_beats_q;

endmodule
`default_nettype wire

// File: tb/tb_vec_accum.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_vec_accum                                                  |
// | Purpose  : Scoreboard bench for vec_accum. Stimulus pushes expected      |
// |            results; monitors pop and compare on every consumed result.   |
// |            dut1 uses ACC_W=32, dut2 uses ACC_W=20 for the overflow case. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_vec_accum;

  typedef struct {
    longint data;
    longint beats;
    longint ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] in_data = '0;
  logic        in_last = 1'b0;

  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_ovf;
  logic [31:0] out_data;
  logic [15:0] out_beats;

  logic        in_valid2 = 1'b0, in_ready2, out_valid2, out_ready2 = 1'b1, out_ovf2;
  logic [19:0] out_data2;
  logic [15:0] out_beats2;

  int n_vec  = 0;
  int n_miss = 0;
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  vec_accum #(.LANES(4), .IN_W(16), .ACC_W(32), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_beats(out_beats),
    .out_ovf(out_ovf)
  );

  vec_accum #(.LANES(4), .IN_W(16), .ACC_W(20), .CNT_W(16)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_data(out_data2), .out_beats(out_beats2),
    .out_ovf(out_ovf2)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pack(input int a, input int b, input int c, input int d);
    logic [15:0] la, lb, lc, ld;
    la = a[15:0]; lb = b[15:0]; lc = c[15:0]; ld = d[15:0];
    return {ld, lc, lb, la};
  endfunction

  function automatic exp_t mk(input longint data, input longint beats, input longint ovf);
    exp_t e;
    e.data = data; e.beats = beats; e.ovf = ovf;
    return e;
  endfunction

  // Monitors: compare whenever a result is consumed on the coming edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q1.size() == 0) begin
        check("dut1_unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("dut1_data",  longint'($signed(out_data)), e.data);
        check("dut1_beats", longint'(out_beats), e.beats);
        check("dut1_ovf",   longint'(out_ovf), e.ovf);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid2 && out_ready2) begin
      if (q2.size() == 0) begin
        check("dut2_unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = q2.pop_front();
        check("dut2_data",  longint'($signed(out_data2)), e.data);
        check("dut2_beats", longint'(out_beats2), e.beats);
        check("dut2_ovf",   longint'(out_ovf2), e.ovf);
      end
    end
  end

  // Present one beat and hold it until accepted (bounded).
  task automatic send(input int which, input logic [63:0] d, input logic last);
    bit acc;
    int guard;
    in_data = d;
    in_last = last;
    if (which == 1) in_valid = 1'b1;
    else            in_valid2 = 1'b1;
    acc   = 1'b0;
    guard = 0;
    while (!acc && guard < 50) begin
      @(negedge clk);
      acc = (which == 1) ? in_ready : in_ready2;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) check("beat_accept_timeout", 0, 1);
    in_valid  = 1'b0;
    in_valid2 = 1'b0;
    in_last   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;

    // 1. reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_in_ready",  longint'(in_ready), 1);
    check("rst_out_data",  longint'(out_data), 0);
    check("rst_out_beats", longint'(out_beats), 0);
    check("rst_out_ovf",   longint'(out_ovf), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 2. single-beat vector: 1+2+3+4
    q1.push_back(mk(10, 1, 0));
    send(1, pack(1, 2, 3, 4), 1'b1);
    check("t2_latency_valid", longint'(out_valid), 1);
    repeat (2) @(posedge clk); #1;

    // 3. three beats: 50 + (-131072) + 4
    q1.push_back(mk(-131018, 3, 0));
    send(1, pack(100, -50, 7, -7), 1'b0);
    send(1, pack(-32768, -32768, -32768, -32768), 1'b0);
    send(1, pack(1, 1, 1, 1), 1'b1);
    repeat (2) @(posedge clk); #1;

    // 4. backpressure, then consume and load on the same edge
    out_ready = 1'b0;
    q1.push_back(mk(4, 1, 0));
    send(1, pack(1, 1, 1, 1), 1'b1);
    in_data  = pack(2, 2, 2, 2);
    in_last  = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_in_ready_blocked", longint'(in_ready), 0);
      check("t4_out_data_stable", longint'(out_data), 4);
      check("t4_out_valid_held",  longint'(out_valid), 1);
    end
    @(posedge clk); #1;
    q1.push_back(mk(8, 1, 0));
    out_ready = 1'b1;
    @(negedge clk);
    check("t4_in_ready_passthru", longint'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("t4_valid_after_swap", longint'(out_valid), 1);
    check("t4_data_after_swap",  longint'(out_data), 8);
    repeat (2) @(posedge clk); #1;

    // 5. ACC_W=20: five beats of 4*32767 = 655340 total
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
`ifdef ACC_SAT_EN
        q2.push_back(mk(524287, 5, 1));
`else
        q2.push_back(mk(-393236, 5, 0));
`endif
      end
      send(2, pack(32767, 32767, 32767, 32767), (i == 4));
    end
    repeat (2) @(posedge clk); #1;

    // 6. reset mid-vector discards the partial sum
    send(1, pack(5, 5, 5, 5), 1'b0);
    send(1, pack(5, 5, 5, 5), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_out_valid", longint'(out_valid), 0);
    check("t6_rst_out_data",  longint'(out_data), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    q1.push_back(mk(4, 1, 0));
    send(1, pack(1, 1, 1, 1), 1'b1);

    guard = 0;
    while ((q1.size() + q2.size()) != 0 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("scoreboard_drained", longint'(q1.size() + q2.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
